// File: rtl/dispatch_pkg.sv
// Shared types and RS identifiers for the dual-issue rename/dispatch stage.
// An RS tag is the same value as its RSID.
package dispatch_pkg;
   localparam int NUM_REGS = 32;
   localparam int NUM_RS   = 8;

   localparam logic [2:0] A0 = 3'd0, A1 = 3'd1, M0 = 3'd2, M1 = 3'd3,
                          L0 = 3'd4, L1 = 3'd5, S0 = 3'd6, S1 = 3'd7;

   typedef enum logic [1:0] {OP_ADD = 2'd0, OP_MUL = 2'd1, OP_LD = 2'd2, OP_ST = 2'd3} op_e;

   typedef struct packed {
      logic        valid;
      logic [2:0]  tag;
      logic [31:0] value;
   } src_t;

   typedef struct packed {
      op_e        op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } instr_t;

   typedef struct packed {
      logic [2:0] rsid;
      src_t       src1;
      src_t       src2;
   } rs_pkt_t;

   typedef struct packed {
      logic [2:0]  tag;
      logic [31:0] value;
   } cdb_t;

   // Stores and writes to r0 never produce a new mapping.
   function automatic logic renames(instr_t i);
      return (i.op != OP_ST) && (i.rd != 5'd0);
   endfunction
endpackage

// File: rtl/rat_regfile.sv
// Tag-tracking register file: combinational read ports with CDB bypass,
// two rename write ports and CDB tag-match writeback.
module rat_regfile
   import dispatch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0][4:0] rd_addr,
   output src_t [3:0]      rd_data,
   input  logic [1:0]      ren_en,
   input  logic [1:0][4:0] ren_addr,
   input  logic [1:0][2:0] ren_tag,
   input  logic            cdb_valid,
   input  cdb_t            cdb
);
   logic [NUM_REGS-1:0]       vld;
   logic [NUM_REGS-1:0][2:0]  tag;
   logic [NUM_REGS-1:0][31:0] val;

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < 4; p++) begin
         if (rd_addr[p] == 5'd0)
            rd_data[p] = '{valid: 1'b1, tag: 3'd0, value: 32'd0};
         else if (vld[rd_addr[p]])
            rd_data[p] = '{valid: 1'b1, tag: 3'd0, value: val[rd_addr[p]]};
         else if (cdb_valid && tag[rd_addr[p]] == cdb.tag)
            rd_data[p] = '{valid: 1'b1, tag: 3'd0, value: cdb.value};
         else
            rd_data[p] = '{valid: 1'b0, tag: tag[rd_addr[p]], value: 32'd0};
      end
   end

   // Younger rename beats older rename beats CDB; r0 is never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '1;
         tag <= '0;
         val <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (ren_en[1] && ren_addr[1] == 5'(r)) begin
               vld[r] <= 1'b0;
               tag[r] <= ren_tag[1];
            end else if (ren_en[0] && ren_addr[0] == 5'(r)) begin
               vld[r] <= 1'b0;
               tag[r] <= ren_tag[0];
            end else if (cdb_valid && !vld[r] && tag[r] == cdb.tag) begin
               vld[r] <= 1'b1;
               val[r] <= cdb.value;
            end
         end
      end
   end
endmodule

// File: rtl/dispatch_unit.sv
// Dual-issue in-order dispatch: RS allocation, operand read/rename,
// intra-pair dependency override and registered RS packets.
module dispatch_unit
   import dispatch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  in_valid,
   input  logic [16:0] in_instr0,
   input  logic [16:0] in_instr1,
   output logic [1:0]  in_accept,
   input  logic [1:0]  add_done,
   input  logic [1:0]  mul_done,
   input  logic [1:0]  ld_done,
   input  logic [1:0]  st_done,
   input  logic        cdb_valid,
   input  logic [2:0]  cdb_tag,
   input  logic [31:0] cdb_value,
   output logic [74:0] i1,
   output logic [74:0] i2,
   output logic        i1_valid,
   output logic        i2_valid
);
   instr_t              ins0, ins1;
   logic [NUM_RS-1:0]   done, pend, free, alloc;
   logic [1:0]          c0, c1, pair0, pair1;
   logic [2:0]          rsid0, rsid1;
   logic                acc0, acc1;
   src_t [3:0]          rd;
   src_t                s11, s12;
   rs_pkt_t             pkt0, pkt1;
   cdb_t                cdb;

   assign ins0 = instr_t'(in_instr0);
   assign ins1 = instr_t'(in_instr1);
   assign cdb  = '{tag: cdb_tag, value: cdb_value};
   assign done = {st_done, ld_done, mul_done, add_done};
   // pend masks entries whose done bit has not yet dropped after allocation.
   assign free = done & ~pend;

   always_comb begin
      c0    = ins0.op;
      c1    = ins1.op;
      pair0 = free[{c0, 1'b0} +: 2];
      rsid0 = {c0, ~pair0[0]};
      acc0  = !rst && in_valid[0] && (|pair0);
      pair1 = free[{c1, 1'b0} +: 2];
      if (acc0 && c1 == c0)
         pair1[rsid0[0]] = 1'b0;
      rsid1 = {c1, ~pair1[0]};
      acc1  = acc0 && in_valid[1] && (|pair1);
      alloc = '0;
      if (acc0) alloc[rsid0] = 1'b1;
      if (acc1) alloc[rsid1] = 1'b1;
   end

   assign in_accept = {acc1, acc0};

   rat_regfile u_rf (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   ({ins1.rs2, ins1.rs1, ins0.rs2, ins0.rs1}),
      .rd_data   (rd),
      .ren_en    ({acc1 && renames(ins1), acc0 && renames(ins0)}),
      .ren_addr  ({ins1.rd, ins0.rd}),
      .ren_tag   ({rsid1, rsid0}),
      .cdb_valid (cdb_valid),
      .cdb       (cdb)
   );

   // Instr1 reading instr0's destination must wait on instr0's tag.
   always_comb begin
      s11 = rd[2];
      s12 = rd[3];
      if (renames(ins0) && ins1.rs1 == ins0.rd) s11 = '{valid: 1'b0, tag: rsid0, value: 32'd0};
      if (renames(ins0) && ins1.rs2 == ins0.rd) s12 = '{valid: 1'b0, tag: rsid0, value: 32'd0};
   end

   assign pkt0 = '{rsid: rsid0, src1: rd[0], src2: rd[1]};
   assign pkt1 = '{rsid: rsid1, src1: s11, src2: s12};

   always_ff @(posedge clk) begin
      if (rst) begin
         pend     <= '0;
         i1       <= '0;
         i2       <= '0;
         i1_valid <= 1'b0;
         i2_valid <= 1'b0;
      end else begin
         pend     <= alloc;
         i1       <= acc0 ? pkt0 : '0;
         i2       <= acc1 ? pkt1 : '0;
         i1_valid <= acc0;
         i2_valid <= acc1;
      end
   end
endmodule
